riscv_alu_mc: RTL
=================

// Module: riscv_alu_mc
// PURPOSE
//  Multi-cycle, parametrised execute unit for the RISC-V core.
//  Covers the base ALU ops (add/sub/logic/shift/compare) and the branch compare, plus the
//  RV32M multiply/divide group as iterative shift-add and restoring-divide operations.
//  Sits in EX stage between decode operand muxes and writeback; valid/ready on both sides.
// PARAMETERS
//  WIDTH    32  datapath width in bits; power of two, >= 8
//  CNT_W    $clog2(WIDTH)  iteration counter / shift amount width (derived, do not override)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous active-high reset
//  flush        in   1      abort current op (pipeline redirect)
//  in_valid     in   1      operands/op valid
//  in_ready     out  1      unit can accept an op this cycle
//  dataA        in   WIDTH  operand A (rs1)
//  dataB        in   WIDTH  operand B (rs2 or imm)
//  aluOp        in   3      000 ADD, 001 SUB, 010 R/I decode by func, 011 M-ext by func[2:0], 100 BRANCH by func[2:0]
//  func         in   4      {funct7[5],funct3}
//  out_valid    out  1      aluResult/branchFromAlu valid
//  out_ready    in   1      consumer accepts result
//  aluResult    out  WIDTH  result
//  branchFromAlu out 1      branch condition true (aluOp=100 only, else 0)
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, aluResult=0, branchFromAlu=0, counter=0; in_ready=1 next cycle.
//  FSM: IDLE -> DONE (single-cycle op) | BUSY (aluOp=011); BUSY -> DONE when counter==0; DONE -> IDLE on
//   out_ready, or DONE->DONE/BUSY if a new op is accepted in the same cycle.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  Operands and op are latched on accept; inputs are don't-care afterwards.
//  Latency: single-cycle ops out_valid 1 cycle after accept; M-ext ops WIDTH+1 cycles after accept.
//  out_valid held and aluResult/branchFromAlu stable while out_ready=0 (no drop, no change).
//  aluOp=010 func: 0000 ADD, 1000 SUB, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU,
//   0100 XOR, 0110 OR, 0111 AND; any other code -> result 0.
//  Shifts use dataB[CNT_W-1:0] only. SLT/SLTU result is 0 or 1, zero-extended. Add/sub wrap modulo 2^WIDTH.
//  aluOp=011 func[2:0]: 000 MUL (low), 001 MULH (s*s), 010 MULHSU (s*u), 011 MULHU (u*u),
//   100 DIV, 101 DIVU, 110 REM, 111 REMU. Multiply on magnitudes, 2*WIDTH product, sign fixed at end.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dataA. Skips iteration (1-cycle latency).
//  Signed overflow (A = most-negative, B = -1): DIV -> A, REM -> 0. Skips iteration (1-cycle latency).
//  REM sign follows dividend; DIV truncates toward zero.
//  aluOp=100 func[2:0]: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU -> branchFromAlu; aluResult = A-B.
//   Undefined branch codes -> branchFromAlu=0.
//  aluOp 101..111 -> aluResult 0, branchFromAlu 0, single-cycle.
//  flush: forces IDLE, out_valid=0, no result for the aborted op; in_ready=1 next cycle.
//   flush takes priority over in_valid in the same cycle.
//  rst during BUSY behaves as flush plus full state clear.
// STRUCTURE
//  Package riscv_alu_pkg: aluOp codes, func codes (ALU, M-ext, branch), FSM state encoding, WIDTH default.
//  Sub-module riscv_muldiv_iter: start/busy/done; owns counter, partial product/remainder registers,
//   and the sign-fix logic. It also flags the div-by-zero and overflow early-outs.
//  Top: operand latch, combinational ALU/compare, FSM, output register, handshake.
// TESTING (WIDTH=32)
//  ADD 5+7, SUB 3-5, SRA 0x80000000>>4 -> 0x0000000C, 0xFFFFFFFE, 0xF8000000; each out_valid 1 cycle after accept.
//  MUL/MULHU with A=B=0xFFFFFFFF -> 0x00000001 / 0xFFFFFFFE; MULH -7*3 -> 0xFFFFFFFF; out_valid at cycle 33.
//  DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; each 1-cycle; DIV -7/2 -> -3, REM -> -1.
//  BLT A=-1,B=1 -> branch 1; BLTU same operands -> 0; BEQ 4,4 -> 1; BNE 4,4 -> 0.
//  Backpressure: out_ready=0 for 5 cycles after a result -> in_ready=0 and result stable; out_ready=1 with
//   in_valid=1 -> new op accepted in that same cycle.
//  flush at cycle 10 of a DIVU -> no out_valid; next ADD accepted the following cycle; rst mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the multi-cycle EX unit: opcode groups, func codes,
// FSM state type and the default datapath width.
package riscv_alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_SUB    = 3'b001;
    localparam logic [2:0] ALUOP_RI     = 3'b010;
    localparam logic [2:0] ALUOP_MEXT   = 3'b011;
    localparam logic [2:0] ALUOP_BRANCH = 3'b100;

    // {funct7[5], funct3} for the R/I group
    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_SLL  = 4'b0001;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_SRA  = 4'b1101;
    localparam logic [3:0] F_SLT  = 4'b0010;
    localparam logic [3:0] F_SLTU = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_AND  = 4'b0111;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [2:0] B_EQ  = 3'b000;
    localparam logic [2:0] B_NE  = 3'b001;
    localparam logic [2:0] B_LT  = 3'b100;
    localparam logic [2:0] B_GE  = 3'b101;
    localparam logic [2:0] B_LTU = 3'b110;
    localparam logic [2:0] B_GEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction applied to the final step.
module riscv_muldiv_iter
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_early,
    output logic [WIDTH-1:0] o_early_result,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [2:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opr;

    logic               w_is_div, w_a_sop, w_b_sop, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic               w_div_zero, w_div_ovf;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH-1:0]   w_rem_sub, w_hi_nxt, w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_is_div = i_op[2];
    assign w_a_sop  = (i_op == M_MUL) | (i_op == M_MULH) | (i_op == M_MULHSU) |
                      (i_op == M_DIV) | (i_op == M_REM);
    assign w_b_sop  = (i_op == M_MUL) | (i_op == M_MULH) | (i_op == M_DIV) | (i_op == M_REM);
    assign w_a_neg  = w_a_sop & i_a[WIDTH-1];
    assign w_b_neg  = w_b_sop & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    assign w_div_zero = w_is_div & (i_b == '0);
    assign w_div_ovf  = ((i_op == M_DIV) | (i_op == M_REM)) &
                        (i_a == {1'b1, {(WIDTH-1){1'b0}}}) & (i_b == '1);
    assign o_early    = w_div_zero | w_div_ovf;

    // op[1] separates remainder from quotient within the divide group
    always_comb begin
        o_early_result = '0;
        if (w_div_zero)
            o_early_result = i_op[1] ? i_a : '1;
        else if (w_div_ovf)
            o_early_result = i_op[1] ? '0 : i_a;
    end

    // One iteration: multiply shifts {carry,hi,lo} right, divide shifts {hi,lo} left
    assign w_sum     = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opr}) : {1'b0, r_hi};
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_rem_sub = w_shift[WIDTH-1:0] - r_opr;

    always_comb begin
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_op[2]) begin
            if (w_shift >= {1'b0, r_opr}) begin
                w_hi_nxt = w_rem_sub;
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_comb begin
        if (r_op[2])
            o_result = r_op[1] ? (r_neg ? -w_hi_nxt : w_hi_nxt)
                               : (r_neg ? -w_lo_nxt : w_lo_nxt);
        else
            o_result = (r_op[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0]
                                            : w_prod_fix[2*WIDTH-1:WIDTH];
    end

    assign o_done = r_busy & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_op   <= '0;
            r_neg  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opr  <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_cnt  <= CNT_W'(WIDTH-1);
            r_busy <= 1'b1;
            r_op   <= i_op;
            r_neg  <= (w_is_div & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_hi   <= '0;
            r_lo   <= w_is_div ? w_a_mag : w_b_mag;
            r_opr  <= w_is_div ? w_b_mag : w_a_mag;
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == '0)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/riscv_alu_mc.sv
// EX-stage execute unit: single-cycle ALU/branch compare plus an iterative
// RV32M engine, behind a registered result with valid/ready on both sides.
module riscv_alu_mc
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [2:0]       aluOp,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             branchFromAlu,
    output state_e           o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_branch;

    logic [CNT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_add, w_sub, w_result, w_md_early_result, w_md_result;
    logic             w_lt, w_ltu, w_eq, w_branch;
    logic             w_md_early, w_md_done, w_md_iter, w_accept;

    // Handshake: a transfer happens on a cycle where valid and ready are both high;
    // the producer holds its payload until then, and flush cancels any transfer.
    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_md_iter = (aluOp == ALUOP_MEXT) & ~w_md_early;

    assign w_shamt = dataB[CNT_W-1:0];
    assign w_add   = dataA + dataB;
    assign w_sub   = dataA - dataB;
    assign w_lt    = $signed(dataA) < $signed(dataB);
    assign w_ltu   = dataA < dataB;
    assign w_eq    = dataA == dataB;

    always_comb begin
        w_result = '0;
        w_branch = 1'b0;
        case (aluOp)
            ALUOP_ADD: w_result = w_add;
            ALUOP_SUB: w_result = w_sub;
            ALUOP_RI: begin
                case (func)
                    F_ADD:   w_result = w_add;
                    F_SUB:   w_result = w_sub;
                    F_SLL:   w_result = dataA << w_shamt;
                    F_SRL:   w_result = dataA >> w_shamt;
                    F_SRA:   w_result = WIDTH'($signed(dataA) >>> w_shamt);
                    F_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
                    F_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_ltu};
                    F_XOR:   w_result = dataA ^ dataB;
                    F_OR:    w_result = dataA | dataB;
                    F_AND:   w_result = dataA & dataB;
                    default: w_result = '0;
                endcase
            end
            ALUOP_MEXT: w_result = w_md_early_result;
            ALUOP_BRANCH: begin
                w_result = w_sub;
                case (func[2:0])
                    B_EQ:    w_branch = w_eq;
                    B_NE:    w_branch = ~w_eq;
                    B_LT:    w_branch = w_lt;
                    B_GE:    w_branch = ~w_lt;
                    B_LTU:   w_branch = w_ltu;
                    B_GEU:   w_branch = ~w_ltu;
                    default: w_branch = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    riscv_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk            (clk),
        .rst            (rst),
        .i_abort        (flush),
        .i_start        (w_accept & w_md_iter),
        .i_op           (func[2:0]),
        .i_a            (dataA),
        .i_b            (dataB),
        .o_early        (w_md_early),
        .o_early_result (w_md_early_result),
        .o_done         (w_md_done),
        .o_result       (w_md_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_md_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept)
                    w_state_nxt = w_md_iter ? ST_BUSY : ST_DONE;
                else if (out_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush)
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Result register only moves on a new accept or on the last iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_branch <= 1'b0;
        end else if (w_accept & ~w_md_iter) begin
            r_result <= w_result;
            r_branch <= w_branch;
        end else if ((r_state == ST_BUSY) & w_md_done & ~flush) begin
            r_result <= w_md_result;
            r_branch <= 1'b0;
        end
    end

    assign out_valid     = (r_state == ST_DONE);
    assign aluResult     = r_result;
    assign branchFromAlu = r_branch;
    assign o_dbg_state   = r_state;

endmodule
